// File: rtl/nn_pkg.sv
// Shared definitions for the NN streaming stages: FSM encodings, default pixel width
// and the signed-max helper used by the pooling blocks.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } nn_state_e;

  localparam int NN_DATA_W = 16;
  localparam int NN_MAX_W  = 64;

  // Callers sign-extend into the wide operands and truncate the result back.
  function automatic logic signed [NN_MAX_W-1:0] nn_smax(
    input logic signed [NN_MAX_W-1:0] a,
    input logic signed [NN_MAX_W-1:0] b
  );
    logic signed [NN_MAX_W-1:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer for the even-row partial maxima: one synchronous write port and
// one asynchronous read port. Contents are not reset.
module pool_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic signed [DATA_W-1:0] o_rdata
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  // Storage write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maxpool2d_stream.sv
// 2x2 stride-2 signed max pooling over a row-major pixel stream, en/done controlled.
// Optional macro POOL_RELU_EN clamps negative pooled results to zero.
module maxpool2d_stream
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_pool,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     done
);

  localparam int DEPTH = IMG_W / 2;
  localparam int NOUT  = (IMG_W / 2) * (IMG_H / 2);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW    = $clog2(NOUT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);

  nn_state_e                r_state;
  nn_state_e                w_next_state;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [DATA_W-1:0] r_pair;
  logic                     r_in_done;
  logic [OW-1:0]            r_out_cnt;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_done;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_out_hs;
  logic                     w_start;
  logic                     w_lb_we;
  logic [AW-1:0]            w_lb_addr;
  logic signed [DATA_W-1:0] w_lb_rdata;
  logic signed [DATA_W-1:0] w_pm;
  logic signed [DATA_W-1:0] w_win_max;
  logic signed [DATA_W-1:0] w_result;

  assign w_start  = (r_state == ST_IDLE) && en_pool;
  assign w_accept = in_valid && w_in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and input-ready decode
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en_pool) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_in_ready = (!r_out_valid || out_ready) && !r_in_done;
        if (w_out_hs && (r_out_cnt == OUT_LAST)) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Window arithmetic: horizontal pair max, then vertical max against the line buffer
  always_comb begin
    w_pm      = DATA_W'(nn_smax(NN_MAX_W'(in_data), NN_MAX_W'(r_pair)));
    w_win_max = DATA_W'(nn_smax(NN_MAX_W'(w_lb_rdata), NN_MAX_W'(w_pm)));
`ifdef POOL_RELU_EN
    if (w_win_max[DATA_W-1]) begin
      w_result = '0;
    end else begin
      w_result = w_win_max;
    end
`else
    w_result = w_win_max;
`endif
    w_lb_we   = w_accept && r_col[0] && !r_row[0];
    w_lb_addr = AW'(r_col >> 1);
  end

  // Input position counters and the held even-column pixel
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_col     <= '0;
      r_row     <= '0;
      r_pair    <= '0;
      r_in_done <= 1'b0;
    end else if (w_accept) begin
      if (!r_col[0]) begin
        r_pair <= in_data;
      end
      if (r_col == COL_LAST) begin
        r_col <= '0;
        if (r_row == ROW_LAST) begin
          r_row     <= '0;
          r_in_done <= 1'b1;
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Output register; a new result may load in the cycle the old one drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_next_state == ST_DONE);
      if (w_start) begin
        r_out_cnt <= '0;
      end else if (w_out_hs) begin
        r_out_cnt <= r_out_cnt + OW'(1);
      end
      if (w_accept && r_col[0] && r_row[0]) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_pm),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Self-checking bench for maxpool2d_stream on a 4x4 map: table-driven frames,
// hand-written reset/backpressure sequences and random frames against a reference model.
module tb_maxpool2d_stream;

  localparam int DW   = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  localparam int M_NORMAL = 0;
  localparam int M_BP     = 1;
  localparam int M_BUBBLE = 2;
  localparam int M_ENMID  = 3;

  typedef struct packed {
    logic [NPIX*DW-1:0] pix;
    logic [NOUT*DW-1:0] exp;
    logic [7:0]         mode;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en_pool;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_ready;
  logic                 done;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl [6];

  always #5 clk = ~clk;

  maxpool2d_stream #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_pool   (en_pool),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic signed [DW-1:0] post(input logic signed [DW-1:0] v);
`ifdef POOL_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: plain 2D max over each 2x2 block
  task automatic model(input logic [NPIX*DW-1:0] pix, output logic [NOUT*DW-1:0] exp);
    logic signed [DW-1:0] img [H][W];
    logic signed [DW-1:0] m;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pix[(r*W+c)*DW +: DW];
    for (int pr = 0; pr < H/2; pr++) begin
      for (int pc = 0; pc < W/2; pc++) begin
        m = img[2*pr][2*pc];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (img[2*pr+dr][2*pc+dc] > m) m = img[2*pr+dr][2*pc+dc];
        exp[(pr*(W/2)+pc)*DW +: DW] = post(m);
      end
    end
  endtask

  task automatic run_frame(input logic [NPIX*DW-1:0] pix, input logic [NOUT*DW-1:0] exp,
                           input int mode);
    logic signed [DW-1:0] got[$];
    int hs_cyc[$];
    int acc_cyc [NPIX];
    int last_idx [NOUT];
    int idx, dones, done_cyc, stall, cyc;
    logic signed [DW-1:0] e;
    idx = 0; dones = 0; done_cyc = 0; stall = 0;
    last_idx = '{5, 7, 13, 15};
    // in_valid while IDLE must be ignored
    repeat (2) begin
      @(negedge clk);
      en_pool = 1'b0; in_valid = 1'b1; in_data = -16'sd300; out_ready = 1'b1;
      #1 check("idle_in_ready", 32'(in_ready), 32'sd0);
    end
    @(negedge clk);
    en_pool = 1'b1; in_valid = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      en_pool = (mode == M_ENMID) && (cyc >= 3) && (cyc <= 5);
      if (idx < NPIX) begin
        in_valid = (mode != M_BUBBLE) || (cyc % 2 == 1);
        in_data  = pix[idx*DW +: DW];
      end else begin
        in_valid = (dones > 0);
        in_data  = 16'sh7fff;
      end
      out_ready = 1'b1;
      if (mode == M_BP && out_valid && got.size() == 0 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end
      #1;
      if (out_valid && !out_ready) begin
        check("bp_in_ready", 32'(in_ready), 32'sd0);
        check("bp_hold_data", 32'(out_data), 32'(exp[0 +: DW]));
      end
      if (dones > 0) check("post_done_in_ready", 32'(in_ready), 32'sd0);
      if (in_valid && in_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (dones > 0 && cyc >= done_cyc + 3) break;
    end
    in_valid = 1'b0;
    check("out_count", got.size(), NOUT);
    check("done_count", dones, 1);
    for (int k = 0; k < NOUT && k < got.size(); k++) begin
      e = exp[k*DW +: DW];
      check($sformatf("out_data[%0d]", k), 32'(got[k]), 32'(e));
    end
    if (mode == M_NORMAL && got.size() == NOUT) begin
      for (int k = 0; k < NOUT; k++)
        check($sformatf("latency[%0d]", k), hs_cyc[k], acc_cyc[last_idx[k]] + 1);
      check("done_latency", done_cyc, hs_cyc[NOUT-1] + 1);
    end
  endtask

  initial begin
    logic [NPIX*DW-1:0] rp;
    logic [NOUT*DW-1:0] re;
    int acc;

    // Directed table
    for (int i = 0; i < NPIX; i++) begin
      tbl[0].pix[i*DW +: DW] = 16'(i + 1);
      tbl[1].pix[i*DW +: DW] = (i == 0) ? -16'sd1 : -16'sd5;
      tbl[5].pix[i*DW +: DW] = 16'(NPIX - i);
    end
    tbl[0].exp  = {post(16'sd16), post(16'sd14), post(16'sd8), post(16'sd6)};
    tbl[1].exp  = {post(-16'sd5), post(-16'sd5), post(-16'sd5), post(-16'sd1)};
    tbl[5].exp  = {post(16'sd6), post(16'sd8), post(16'sd14), post(16'sd16)};
    tbl[0].mode = 8'(M_NORMAL);
    tbl[1].mode = 8'(M_NORMAL);
    tbl[5].mode = 8'(M_NORMAL);
    tbl[2] = tbl[0]; tbl[2].mode = 8'(M_BP);
    tbl[3] = tbl[0]; tbl[3].mode = 8'(M_BUBBLE);
    tbl[4] = tbl[0]; tbl[4].mode = 8'(M_ENMID);

    rst = 1'b1; en_pool = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'sd0);
    check("rst_out_data", 32'(out_data), 32'sd0);
    check("rst_done", 32'(done), 32'sd0);
    check("rst_in_ready", 32'(in_ready), 32'sd0);
    @(negedge clk) rst = 1'b0;

    for (int t = 0; t < 6; t++) run_frame(tbl[t].pix, tbl[t].exp, int'(tbl[t].mode));

    // Reset after 7 accepted pixels, then a clean frame
    @(negedge clk) en_pool = 1'b1;
    @(negedge clk) en_pool = 1'b0;
    out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 40 && acc < 7; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(acc + 1);
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    check("mid_reset_fed", acc, 7);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'sd0);
    check("mid_rst_done", 32'(done), 32'sd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'sd0);
    in_valid = 1'b0;
    run_frame(tbl[0].pix, tbl[0].exp, M_NORMAL);

    // Random frames against the reference model
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NPIX; i++) rp[i*DW +: DW] = 16'($urandom);
      model(rp, re);
      run_frame(rp, re, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool2d_stream.md
Name: maxpool2d_stream

Overview:
- Downstream neighbour of Conv2D. It consumes the convolution feature map as a row-major pixel stream.
- Performs 2x2, stride-2 max pooling and emits the pooled map as a row-major stream.
- Started by a one-cycle enable. Signals completion with a done pulse, matching the Conv2D en/done control style so the top-level sequencer can chain the two stages.

Parameters:
- DATA_W, 16, pixel width, two's-complement signed.
- IMG_W, 8, input feature-map width in pixels; must be even and >= 2.
- IMG_H, 8, input feature-map height in pixels; must be even and >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en_pool  in  1  start request, sampled only in IDLE
- in_valid  in  1  input pixel valid
- in_data  in  DATA_W  input pixel (signed)
- in_ready  out  1  block accepts in_data this cycle
- out_valid  out  1  pooled pixel valid
- out_data  out  DATA_W  pooled pixel (signed)
- out_ready  in  1  consumer accepts out_data
- done  out  1  one-cycle pulse when the whole map has been pooled and drained

Behaviour:
- Reset (rst=1 at a clk edge, at any time including mid-frame):
  - state=IDLE; col, row and pair registers = 0; line buffer contents don't-care.
  - in_ready=0, out_valid=0, out_data=0, done=0.
- FSM states:
  - IDLE -> RUN on en_pool=1.
  - RUN -> DONE on the cycle the last pooled pixel (index IMG_W/2*IMG_H/2-1) is handshaken out.
  - DONE -> IDLE unconditionally. done=1 only while in DONE (exactly one cycle).
  - en_pool is ignored outside IDLE.
- Input handshake: in_ready = (state==RUN) && (!out_valid || out_ready) && !frame_in_complete. A pixel is accepted when in_valid && in_ready.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance per accepted pixel. col wraps to 0 and row increments at IMG_W-1. After the last pixel (row IMG_H-1, col IMG_W-1), frame_in_complete is set and no further input is accepted.
- Even col: store the pixel in the pair register.
- Odd col: pm = signed max(pair, in_data).
  - Even row: linebuf[col>>1] <= pm.
  - Odd row: out_data <= signed max(linebuf[col>>1], pm), out_valid <= 1 on the next edge (latency 1 cycle from accepting the window's last pixel).
- Output register: out_valid stays high with out_data stable until out_ready=1. A new result may load in the same cycle the old one is consumed (full throughput, no bubble).
- Comparisons are signed, and ties select either operand (values are equal). No width growth; out_data is DATA_W.
- Line buffer: IMG_W/2 entries x DATA_W, one write per even-row pair, one read per odd-row pair. Read and write never hit the same row phase.
- Boundary conditions:
  - in_valid while IDLE/DONE: ignored, in_ready=0.
  - out_ready while out_valid=0: no effect.
  - Ordering when the final output handshake and DONE entry coincide: done asserts the cycle after that handshake.

Optional Feature:
- Macro POOL_RELU_EN.
  - Defined: the pooled result is clamped, so negative values emit 0 (ReLU fused after pooling). Applied at out_data load, no added latency.
  - Undefined: raw signed maximum is emitted.

Decomposition:
- Shared package/include (nn_pkg): FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default DATA_W, and the signed-max function used by this block and future pooling stages.
- One natural sub-module: pool_line_buf (parameterised DATA_W and DEPTH=IMG_W/2; single write port and single async-read port) holding the even-row partial maxima.

Test Plan:
- IMG_W=IMG_H=4, en_pool pulse, stream 1..16 row-major with out_ready=1 -> outputs 6,8,14,16 in order, each 1 cycle after pixels 6,8,14,16 accepted. done pulses once, 1 cycle after the 4th output handshake.
- Signed data: 4x4 all -5 except pixel 0 = -1 -> outputs -1,-5,-5,-5. With POOL_RELU_EN: 0,0,0,0.
- Backpressure: out_ready=0 for 5 cycles when first result 6 appears -> out_data holds 6, in_ready=0 while out_valid && !out_ready, no pixel lost. Final sequence still 6,8,14,16.
- Bubbly input: in_valid toggling 1/0 every cycle -> same outputs as scenario 1; counters advance only on handshakes.
- Reset mid-frame: after 7 pixels assert rst 1 cycle -> out_valid=0, done=0, in_ready=0 next cycle. New en_pool plus a full frame of 1..16 -> 6,8,14,16.
- en_pool asserted during RUN and in_valid during IDLE -> both ignored; output count is exactly 4 and exactly one done pulse per frame.
